data_mem_lsu: RTL and testbench

//  Load/store unit between the execute stage and the 256x8 data memory. Takes one request per

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_stack_ptr.sv | 50 +++++
 rtl/data_mem_lsu.sv | 181 ++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared op and state encodings for the data-memory load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] OP_LD   = 2'b00;
  localparam logic [1:0] OP_ST   = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_DUMP   = 2'd3
  } lsu_state_e;

  function automatic logic op_is_write(input logic [1:0] op);
    return (op == OP_ST) || (op == OP_PUSH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_stack_ptr.sv
// ============================================================================
//  Module      : lsu_stack_ptr
//  Description : Hardware stack pointer with full/empty flags and SP / SP+1 addresses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_stack_ptr #(
  parameter logic [7:0] STACK_TOP  = 8'hFF,
  parameter logic [7:0] STACK_BASE = 8'hC0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] sp_o,
  output logic [7:0] sp_plus1_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0] sp_q;
  logic [7:0] sp_d;

  always_comb begin
    sp_d = sp_q;
    if (inc_i) begin
      sp_d = sp_q + 8'd1;
    end else if (dec_i) begin
      sp_d = sp_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q <= STACK_TOP;
    end else begin
      sp_q <= sp_d;
    end
  end

  // SP points at the next free slot, so the stack grows downward from STACK_TOP.
  assign sp_o       = sp_q;
  assign sp_plus1_o = sp_q + 8'd1;
  assign full_o     = (sp_q == (STACK_BASE - 8'd1));
  assign empty_o    = (sp_q == STACK_TOP);

endmodule

`default_nettype wire

// File: rtl/data_mem_lsu.sv
// ============================================================================
//  Module      : data_mem_lsu
//  Description : Load/store unit (LD/ST/PUSH/POP) in front of a 256x8 data memory.
//                Optional memory dump support is built when LSU_DUMP_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter logic [7:0] STACK_TOP   = 8'hFF,
  parameter logic [7:0] STACK_BASE  = 8'hC0,
  parameter int         DUMP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] sp,
`ifdef LSU_DUMP_EN
  input  logic       dump_req,
`endif
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_en,
  input  logic [7:0] mem_rdata,
  output logic       mem_pen
);

  lsu_state_e state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic       w_sp_inc, w_sp_dec, w_full, w_empty, w_err;
  logic       w_we, w_en, w_pen;
  logic [7:0] w_sp_plus1;

`ifdef LSU_DUMP_EN
  localparam int c_cnt_w = $clog2(DUMP_CYCLES + 1);
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
`endif

  lsu_stack_ptr #(
    .STACK_TOP (STACK_TOP),
    .STACK_BASE(STACK_BASE)
  ) u_stack_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (w_sp_inc),
    .dec_i     (w_sp_dec),
    .sp_o      (sp),
    .sp_plus1_o(w_sp_plus1),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign w_err = ((req_op == OP_PUSH) && w_full) || ((req_op == OP_POP) && w_empty);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    w_sp_inc   = 1'b0;
    w_sp_dec   = 1'b0;
    w_we       = 1'b0;
    w_en       = 1'b0;
    w_pen      = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
`ifdef LSU_DUMP_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Error ops skip ACCESS so memory and SP are never touched.
          if (w_err) begin
            state_d    = S_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = 8'h00;
          end else begin
            state_d = S_ACCESS;
            op_d    = req_op;
            wdata_d = req_wdata;
            case (req_op)
              OP_PUSH: addr_d = sp;
              OP_POP:  addr_d = w_sp_plus1;
              default: addr_d = req_addr;
            endcase
          end
        end
`ifdef LSU_DUMP_EN
        else if (dump_req) begin
          state_d = S_DUMP;
          cnt_d   = '0;
        end
`endif
      end
      S_ACCESS: begin
        state_d   = S_RESP;
        rsp_err_d = 1'b0;
        if (op_is_write(op_q)) begin
          w_we       = 1'b1;
          rsp_data_d = 8'h00;
        end else begin
          w_en       = 1'b1;
          rsp_data_d = mem_rdata;
        end
        w_sp_dec = (op_q == OP_PUSH);
        w_sp_inc = (op_q == OP_POP);
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef LSU_DUMP_EN
      S_DUMP: begin
        w_pen = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_cnt_w'(DUMP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_LD;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
`ifdef LSU_DUMP_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef LSU_DUMP_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Strobes are gated by rst_n so a reset edge can never complete a write.
  assign mem_we    = w_we & rst_n;
  assign mem_en    = w_en & rst_n;
  assign mem_pen   = w_pen;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
// ============================================================================
//  Module      : tb_data_mem_lsu
//  Description : Randomised scoreboard bench for data_mem_lsu with a 256x8 memory model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_lsu;

  localparam logic [1:0] T_LD = 2'd0, T_ST = 2'd1, T_PUSH = 2'd2, T_POP = 2'd3;
  localparam logic [7:0] T_TOP = 8'hFF, T_FULL = 8'hBF;
  localparam int         T_DUMP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready;
  logic [1:0] req_op = 2'd0;
  logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [7:0] rsp_data, sp, mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, mem_en, mem_pen;
  logic       dump_req = 1'b0;

  data_mem_lsu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .sp       (sp),
`ifdef LSU_DUMP_EN
    .dump_req (dump_req),
`endif
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_en   (mem_en),
    .mem_rdata(mem_rdata),
    .mem_pen  (mem_pen)
  );

  always #5 clk = ~clk;

  // Environment memory: synchronous write, combinational read that is 0 unless enabled.
  logic [7:0] tbmem [256];
  always @(posedge clk) if (mem_we) tbmem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_en ? tbmem[mem_addr] : 8'h00;

  // Reference model state.
  logic [7:0] ref_mem [256];
  logic [7:0] ref_sp;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [7:0] sp_after;
    int         lat;
  } exp_rsp_t;

  exp_rsp_t   sb_q [$];
  logic       acc_pend = 1'b0, acc_we, acc_en;
  logic [7:0] acc_addr, acc_wdata;
  int         n_tests = 0, n_fail = 0;
  int         cyc = 0, accept_cyc = 0;
  int         hold = 0;
  logic       lat_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writeback side: mostly ready, with occasional stalls and forced hold windows.
  always @(posedge clk) begin
    #1;
    if (hold > 0) begin
      rsp_ready = 1'b0;
      hold--;
    end else begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: memory strobes against the expected access, responses against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we || mem_en) begin
        if (!acc_pend) begin
          chk("unexpected_mem_access", {mem_we, mem_en, mem_addr}, 10'h0);
        end else begin
          chk("mem_access", {mem_we, mem_en, mem_addr, (mem_we ? mem_wdata : 8'h00)},
              {acc_we, acc_en, acc_addr, (acc_we ? acc_wdata : 8'h00)});
          acc_pend = 1'b0;
        end
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          if (!lat_done) begin
            chk("latency", cyc - accept_cyc, sb_q[0].lat);
            lat_done = 1'b1;
          end
          chk("rsp_data", rsp_data, sb_q[0].data);
          chk("rsp_err", rsp_err, sb_q[0].err);
          chk("req_ready_in_resp", req_ready, 1'b0);
          if (rsp_ready) begin
            chk("sp_after", sp, sb_q[0].sp_after);
            void'(sb_q.pop_front());
            lat_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    exp_rsp_t e;
    int t;
    t = 0;
    while (!req_ready) begin
      @(posedge clk); #1; t++;
      if (t > 50) begin chk("ready_timeout", 0, 1); return; end
    end
    e.err = ((op == T_PUSH) && (ref_sp == T_FULL)) || ((op == T_POP) && (ref_sp == T_TOP));
    e.data = 8'h00;
    e.lat  = e.err ? 1 : 2;
    if (!e.err) begin
      acc_pend = 1'b1;
      acc_we = 1'b0; acc_en = 1'b0; acc_wdata = d;
      case (op)
        T_LD:   begin acc_en = 1'b1; acc_addr = a; e.data = ref_mem[a]; end
        T_ST:   begin acc_we = 1'b1; acc_addr = a; ref_mem[a] = d; end
        T_PUSH: begin acc_we = 1'b1; acc_addr = ref_sp; ref_mem[ref_sp] = d; ref_sp = ref_sp - 8'd1; end
        default: begin ref_sp = ref_sp + 8'd1; acc_en = 1'b1; acc_addr = ref_sp; e.data = ref_mem[ref_sp]; end
      endcase
    end
    e.sp_after = ref_sp;
    sb_q.push_back(e);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    @(posedge clk);
    accept_cyc = cyc;
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    t = 0;
    while (sb_q.size() != 0 && t < 60) begin @(posedge clk); #1; t++; end
    if (sb_q.size() != 0) begin
      chk("rsp_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    chk("access_done", {31'd0, acc_pend}, 32'd0);
    acc_pend = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    ref_sp = T_TOP; sb_q.delete(); acc_pend = 1'b0; lat_done = 1'b0;
  endtask

  initial begin
    int errs, hi;
    for (int i = 0; i < 256; i++) begin tbmem[i] = 8'h00; ref_mem[i] = 8'h00; end
    do_reset();
    chk("reset_sp", sp, 8'hFF);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_data, mem_pen, req_ready}, {1'b0, 1'b0, 8'h00, 1'b0, 1'b1});

    // Underflow right after reset.
    issue(T_POP, 8'h00, 8'h00);
    chk("underflow_sp", sp, 8'hFF);
    // Store then load.
    issue(T_ST, 8'h10, 8'hA5);
    issue(T_LD, 8'h10, 8'h00);
    // Stack round trip.
    issue(T_PUSH, 8'h00, 8'h11);
    issue(T_PUSH, 8'h00, 8'h22);
    issue(T_POP, 8'h00, 8'h00);
    issue(T_POP, 8'h00, 8'h00);
    chk("mem_ff", tbmem[8'hFF], 8'h11);
    // Load under a stalled writeback.
    hold = 7;
    issue(T_LD, 8'h10, 8'h00);
    // Fill the stack then overflow.
    for (int i = 0; i < 64; i++) issue(T_PUSH, 8'h00, 8'($urandom));
    chk("full_sp", sp, 8'hBF);
    issue(T_PUSH, 8'h00, 8'h77);
    chk("overflow_mem_bf", tbmem[8'hBF], ref_mem[8'hBF]);
    chk("overflow_sp", sp, 8'hBF);
    // Random mix against the model.
    for (int i = 0; i < 250; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      issue(2'($urandom_range(0, 3)), a, 8'($urandom));
    end
    // Reset landing on the ACCESS cycle of a store.
    issue(T_ST, 8'h20, 8'h33);
    req_valid = 1'b1; req_op = T_ST; req_addr = 8'h20; req_wdata = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; ref_sp = T_TOP;
    @(posedge clk); #1;
    chk("rst_access_mem20", tbmem[8'h20], 8'h33);
    chk("rst_access_sp", sp, 8'hFF);
    chk("rst_access_rsp_valid", rsp_valid, 1'b0);
    issue(T_LD, 8'h20, 8'h00);

`ifdef LSU_DUMP_EN
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    hi = 0;
    for (int i = 0; i < 3 * T_DUMP; i++) begin
      if (mem_pen) begin
        hi++;
        if (req_ready) chk("ready_in_dump", req_ready, 1'b0);
      end
      @(posedge clk); #1;
    end
    chk("dump_cycles", hi, T_DUMP);
    issue(T_LD, 8'h10, 8'h00);
`endif

    errs = 0;
    for (int i = 0; i < 256; i++) if (tbmem[i] !== ref_mem[i]) errs++;
    chk("memory_image", errs, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
